// File: rtl/toggle_decoder.sv
// Recovers T bits from a toggle-encoded (q, q_bar) link and frames them as
// start bit + WIDTH data bits (LSB first) onto a single-entry valid/ready output.
module toggle_decoder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_en,
  input  logic             q,
  input  logic             q_bar,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overflow,
  output logic             code_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic             prev_q_q, prev_q_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             overflow_q, overflow_d;
  logic             code_err_q, code_err_d;
  logic             bit_dec;

  // A change of the toggle line since the previous strobe encodes a 1.
  assign bit_dec = q ^ prev_q_q;

  always_comb begin
    state_d     = state_q;
    prev_q_d    = prev_q_q;
    shift_d     = shift_q;
    count_d     = count_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overflow_d  = overflow_q;
    code_err_d  = code_err_q;

    if (bit_en) begin
      prev_q_d = q;
      if (q == q_bar) begin
        code_err_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (bit_en && bit_dec) begin
          state_d = SHIFT;
          count_d = '0;
        end
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      SHIFT: begin
        if (bit_en) begin
          shift_d = (shift_q >> 1) | (WIDTH'(bit_dec) << (WIDTH - 1));
          count_d = count_q + CNT_W'(1);
          if (count_q == LAST_IDX) begin
            state_d = DONE;
          end
        end
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
        // A word still waiting with no accept this cycle wins; the new one is lost.
        if (!out_valid_q || out_ready) begin
          out_data_d  = shift_q;
          out_valid_d = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      prev_q_q    <= 1'b0;
      shift_q     <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      code_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q_q    <= prev_q_d;
      shift_q     <= shift_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      code_err_q  <= code_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == SHIFT);
  assign overflow  = overflow_q;
  assign code_err  = code_err_q;

endmodule

// File: tb/tb_toggle_decoder.sv
// Scoreboard bench for toggle_decoder: a frame-level model predicts each
// delivered word, drop and sticky flag; a negedge monitor compares the DUT.
module tb_toggle_decoder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         bit_en = 1'b0;
  logic         q = 1'b0;
  logic         q_bar = 1'b1;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         busy;
  logic         overflow;
  logic         code_err;

  toggle_decoder #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .bit_en    (bit_en),
    .q         (q),
    .q_bar     (q_bar),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .overflow  (overflow),
    .code_err  (code_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Encoder-side state and frame markers written by the driver.
  logic         q_lvl = 1'b0;
  logic         frame_last = 1'b0;
  logic [W-1:0] frame_word = '0;
  bit           rand_ready_en = 1'b0;
  int           busy_cnt = 0;

  // Reference model: one output slot, pending completed word, sticky flags.
  bit           m_full = 1'b0;
  bit           m_ovf = 1'b0;
  bit           m_cerr = 1'b0;
  bit           m_done_pend = 1'b0;
  logic [W-1:0] m_done_word = '0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: a completed frame reaches the output one clock after its last strobe.
  initial forever begin
    @(posedge clk);
    if (!reset) begin
      m_full      = 1'b0;
      m_ovf       = 1'b0;
      m_cerr      = 1'b0;
      m_done_pend = 1'b0;
      exp_q.delete();
    end else begin
      if (bit_en && (q == q_bar)) m_cerr = 1'b1;
      if (m_done_pend) begin
        m_done_pend = 1'b0;
        if (!m_full || out_ready) begin
          m_full = 1'b1;
          exp_q.push_back(m_done_word);
        end else begin
          m_ovf = 1'b1;
        end
      end else if (m_full && out_ready) begin
        m_full = 1'b0;
      end
      if (bit_en && frame_last) begin
        m_done_pend = 1'b1;
        m_done_word = frame_word;
      end
    end
  end

  // Monitor: compare status every cycle, pop the scoreboard on each accept.
  initial forever begin
    @(negedge clk);
    if (busy === 1'b1) busy_cnt++;
    check("out_valid", {31'b0, out_valid}, {31'b0, m_full});
    check("overflow", {31'b0, overflow}, {31'b0, m_ovf});
    check("code_err", {31'b0, code_err}, {31'b0, m_cerr});
    if (out_valid === 1'b1 && exp_q.size() > 0)
      check("out_data", {24'b0, out_data}, {24'b0, exp_q[0]});
    if (out_valid === 1'b1 && out_ready && reset) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_word: got 0x%0h, expected no word", out_data);
      end else begin
        $display("[TB] accepted word 0x%0h", out_data);
        void'(exp_q.pop_front());
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready_en) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic drive_bit(input logic b, input bit bad, input bit last);
    @(posedge clk);
    #1;
    if (b) q_lvl = ~q_lvl;
    q          = q_lvl;
    q_bar      = bad ? q_lvl : ~q_lvl;
    bit_en     = 1'b1;
    frame_last = last;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    bit_en     = 1'b0;
    frame_last = 1'b0;
    q_bar      = ~q;
  endtask

  // Returns one cycle after the last strobe, while the DUT sits in DONE.
  task automatic send_frame(input logic [W-1:0] w, input int bad_idx);
    frame_word = w;
    drive_bit(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < W; i++) drive_bit(w[i], (i == bad_idx), (i == W - 1));
    idle_cycle();
    $display("[TB] sent frame 0x%0h bad_idx=%0d", w, bad_idx);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset      = 1'b0;
    bit_en     = 1'b0;
    frame_last = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    q_lvl = 1'b0;
    q     = 1'b0;
    q_bar = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] w;
    int           bad;

    do_reset();

    // Zero bits only: no start detected.
    repeat (5) drive_bit(1'b0, 1'b0, 1'b0);
    idle_cycle();
    check("idle_busy", {31'b0, busy}, 32'd0);
    check("idle_valid", {31'b0, out_valid}, 32'd0);

    // 0xA5: word appears two clocks after the last strobe, busy for W cycles.
    out_ready = 1'b0;
    busy_cnt  = 0;
    send_frame(8'hA5, -1);
    check("a5_valid_early", {31'b0, out_valid}, 32'd0);
    idle_cycle();
    check("a5_valid", {31'b0, out_valid}, 32'd1);
    check("a5_data", {24'b0, out_data}, 32'hA5);
    check("a5_busy_cycles", busy_cnt, W);
    out_ready = 1'b1;
    idle_cycle();
    out_ready = 1'b0;
    check("a5_consumed", {31'b0, out_valid}, 32'd0);

    // Stalled consumer: second word dropped, overflow set.
    send_frame(8'hA5, -1);
    send_frame(8'h3C, -1);
    idle_cycle();
    check("ovf_data", {24'b0, out_data}, 32'hA5);
    check("ovf_flag", {31'b0, overflow}, 32'd1);
    out_ready = 1'b1;
    idle_cycle();
    out_ready = 1'b0;
    check("ovf_drain", {31'b0, out_valid}, 32'd0);

    // Accept and load in the same DONE cycle.
    do_reset();
    send_frame(8'hA5, -1);
    idle_cycle();
    check("sim_first_valid", {31'b0, out_valid}, 32'd1);
    send_frame(8'h3C, -1);
    out_ready = 1'b1;
    idle_cycle();
    check("sim_data", {24'b0, out_data}, 32'h3C);
    check("sim_valid", {31'b0, out_valid}, 32'd1);
    check("sim_no_ovf", {31'b0, overflow}, 32'd0);
    idle_cycle();
    check("sim_consumed", {31'b0, out_valid}, 32'd0);

    // Code violation mid-frame: flag sticks, frame still decoded from q.
    send_frame(8'h5A, 3);
    idle_cycle();
    check("cerr_flag", {31'b0, code_err}, 32'd1);
    check("cerr_data", {24'b0, out_data}, 32'h5A);
    repeat (3) idle_cycle();
    check("cerr_sticky", {31'b0, code_err}, 32'd1);

    // Reset after 4 data bits, then a clean frame.
    drive_bit(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    do_reset();
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_cerr", {31'b0, code_err}, 32'd0);
    send_frame(8'h0F, -1);
    idle_cycle();
    check("rst_0f_data", {24'b0, out_data}, 32'h0F);
    check("rst_0f_valid", {31'b0, out_valid}, 32'd1);
    idle_cycle();

    // Random frames, gaps with zero strobes, random ready.
    rand_ready_en = 1'b1;
    busy_cnt      = 0;
    for (int f = 0; f < 40; f++) begin
      repeat ($urandom_range(0, 3)) begin
        if ($urandom_range(0, 1) == 1) drive_bit(1'b0, 1'b0, 1'b0);
        else idle_cycle();
      end
      w   = W'($urandom);
      bad = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, W - 1)) : -1;
      send_frame(w, bad);
    end
    idle_cycle();
    idle_cycle();
    check("rand_busy_cycles", busy_cnt, 40 * W);

    rand_ready_en = 1'b0;
    out_ready     = 1'b1;
    repeat (4) idle_cycle();
    check("drain_empty", exp_q.size(), 32'd0);
    check("drain_valid", {31'b0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
